// File: rtl/wb_step_counter.sv
// Free-running step counter on a single Wishbone word, mirrored to LA and IO pads, IRQ on wrap.
// Define COUNTER_STICKY_IRQ_EN to make user_irq[0] a level cleared by a write hit or LA clear.
module wb_step_counter #(
  parameter logic [31:0] COUNT_STEP = 32'd1,
  parameter logic [31:0] COUNT_ADDR = 32'd0,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          IO_PADS    = 38
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [31:0]        la_data_in,
  output logic [31:0]        la_data_out,
  input  logic [31:0]        la_oenb,
  input  logic [IO_PADS-1:0] io_in,
  output logic [IO_PADS-1:0] io_out,
  output logic [IO_PADS-1:0] io_oeb,
  input  logic               user_clock2,
  output logic [2:0]         user_irq
);

  localparam logic [31:0] HIT_ADDR = BASE_ADDR + COUNT_ADDR;

  logic [31:0] count;
  logic [31:0] wr_data;
  logic [32:0] sum;
  logic        hit;
  logic        wr_hit;
  logic        clear;
  logic        pause;
  logic        wrap;
  logic        irq_q;

  // The ack term keeps back-to-back strobes from re-hitting in the ack cycle.
  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i == HIT_ADDR) & ~wbs_ack_o;
  assign wr_hit = hit & wbs_we_i;
  assign clear  = ~la_oenb[1] & la_data_in[1];
  assign pause  = ~la_oenb[0] & la_data_in[0];
  assign sum    = {1'b0, count} + {1'b0, COUNT_STEP};
  assign wrap   = ~clear & ~wr_hit & ~pause & sum[32];

  always_comb begin
    wr_data = count;
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) wr_data[8*b +: 8] = wbs_dat_i[8*b +: 8];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_q     <= 1'b0;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit & ~wbs_we_i) ? count : 32'd0;

      if (clear)       count <= '0;
      else if (wr_hit) count <= wr_data;
      else if (!pause) count <= sum[31:0];

`ifdef COUNTER_STICKY_IRQ_EN
      if (wrap)                 irq_q <= 1'b1;
      else if (clear || wr_hit) irq_q <= 1'b0;
`else
      irq_q <= wrap;
`endif
    end
  end

  assign user_irq    = {2'b00, irq_q};
  assign la_data_out = count;

  // Pads 5:0 and anything above 37 stay inputs driving zero.
  always_comb begin
    io_out        = '0;
    io_out[37:6]  = count;
    io_oeb        = '1;
    io_oeb[37:6]  = '0;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, io_in, user_clock2, la_data_in[31:2], la_oenb[31:2]};

endmodule

// File: doc/wb_step_counter.md
Name: wb_step_counter

Overview:
- One user project instance placed behind the multi-project wrapper, which fans Wishbone, LA and IO out to every instance and selects one.
- Free-running counter advances by a fixed step every clock.
- Counter is readable and writable through a single Wishbone word, observable on LA and IO pads, and pulses an IRQ on wrap.
- Each wrapper slot instantiates it with a distinct step and address offset.

Parameters:
- COUNT_STEP, 1, increment added per enabled cycle; 32-bit unsigned.
- COUNT_ADDR, 0, byte offset of the counter word from BASE_ADDR; multiple of 4.
- BASE_ADDR, 32'h3000_0000, user-area Wishbone base.
- IO_PADS, 38, number of user IO pads; must be at least 38.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- la_data_in  in  32  LA control inputs.
- la_data_out  out  32  LA observation.
- la_oenb  in  32  LA enable, active-low; bit=0 means management drives that bit.
- io_in  in  IO_PADS  unused.
- io_out  out  IO_PADS  pad outputs.
- io_oeb  out  IO_PADS  pad output enables, active-low.
- user_clock2  in  1  unused.
- user_irq  out  3  interrupts.

Behaviour:
- Clock and reset: single clock wb_clk_i; synchronous, active-high reset wb_rst_i; all state updates on the rising edge of wb_clk_i.
- Reset values: count=0, wbs_ack_o=0, wbs_dat_o=0, user_irq=0.
- Reset mid-transaction: aborts the access; no write is applied and no ack is given.
- Address hit: hit = cyc & stb & (adr == BASE_ADDR+COUNT_ADDR) & !wbs_ack_o.
  - Any other address is ignored, with no ack, so the wrapper's ack OR-ing stays clean.
- Handshake: hit in cycle N gives wbs_ack_o=1 in cycle N+1 for exactly one cycle; back-to-back strobes therefore ack every other cycle.
- Read: wbs_dat_o in cycle N+1 = count as it was in cycle N; wbs_dat_o=0 whenever ack=0.
- Write: count in cycle N+1 = byte merge of wbs_dat_i into count per wbs_sel_i. The increment resumes from the written value at N+2.
- LA controls, sampled each cycle:
  - clear = !la_oenb[1] & la_data_in[1].
  - pause = !la_oenb[0] & la_data_in[0].
- Count update priority per cycle: clear (count←0) > WB write > pause (hold) > increment (count←count+COUNT_STEP mod 2^32).
- Wrap IRQ: user_irq[0] is high for one cycle, the cycle after an increment whose 33-bit sum carries out.
  - No pulse on clear or write, even if a write coincides with a would-be carry.
- user_irq[2:1]=0 always.
- Outputs:
  - la_data_out = count.
  - io_out[37:6] = count[31:0], io_out[5:0] = 0.
  - io_oeb[37:6] = 0, io_oeb[5:0] = 1.
  - Pads IO_PADS-1:38, if present, get io_out=0 and io_oeb=1.
- COUNT_STEP=0 is legal; the counter then only changes by write or clear.

Optional Feature:
- Macro: COUNTER_STICKY_IRQ_EN.
- Defined: user_irq[0] is a level that sets on wrap and stays high until a Wishbone write hit or a clear.
  - Set wins if a wrap and a clear/write occur in the same cycle.
- Undefined: one-cycle pulse, as described in Behaviour.

Test Plan:
- Reset with COUNT_STEP=3: hold reset 4 cycles, then release.
  - Required: count reads 0, 3, 6 on the first three cycles after release; all outputs 0 during reset.
- Read access, COUNT_ADDR=8: read at 0x3000_0008.
  - Required: ack one cycle later for exactly one cycle; dat_o equals count of the request cycle.
- Read access at 0x3000_000C:
  - Required: no ack and dat_o=0 for 10 cycles.
- Byte-select write: preset count to 0x1122_3344, then write 0xAABB_CCDD with sel=4'b0101 while paused.
  - Required: count=0x11BB_33DD.
- Wrap pulse: write 0xFFFF_FFFE with step 3 and pause released.
  - Required: next values 0x0000_0001, 0x0000_0004; user_irq[0]=1 for one cycle.
  - With COUNTER_STICKY_IRQ_EN: irq stays high until the next write.
- Priority, with clear and pause asserted via LA (la_oenb[1:0]=0) plus a simultaneous write of 0x55:
  - Required: count=0 and the ack still occurs.
  - With clear deasserted: count=0x55 and holds while paused.
